// File: rtl/seq_shift_add_mult_if.sv
// Operand/product handshake bundle for seq_shift_add_mult.
// The master drives operands and out_ready; the slave is the multiplier.
interface seq_shift_add_mult_if #(
    parameter int WIDTH = 4
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   product;
    logic                 busy;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, product, busy
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, product, busy
    );
endinterface

// File: rtl/seq_shift_add_mult.sv
// WIDTH x WIDTH sequential shift-add multiplier, one multiplier bit per clock.
// Define SIGNED_MULT_EN for two's-complement operands; default is unsigned.
module seq_shift_add_mult #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    seq_shift_add_mult_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t               state_r;
    state_t               state_next_s;
    logic [WIDTH-1:0]     mcand_r;
    logic [2*WIDTH:0]     acc_r;
    logic [2*WIDTH:0]     acc_next_s;
    logic [WIDTH:0]       hi_s;
    logic [CW-1:0]        cnt_r;
    logic                 last_s;
    logic                 accept_s;
    logic                 in_ready_r;
    logic                 out_valid_r;
    logic                 busy_r;
    logic [2*WIDTH-1:0]   product_r;

    assign last_s   = (cnt_r == CW'(WIDTH - 1));
    assign accept_s = bus.in_valid && in_ready_r;

    // Next-state decode for the IDLE -> RUN -> DONE sequence.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) state_next_s = ST_RUN;
                else          state_next_s = ST_IDLE;
            end
            ST_RUN: begin
                if (last_s) state_next_s = ST_DONE;
                else        state_next_s = ST_RUN;
            end
            ST_DONE: begin
                if (bus.out_ready) state_next_s = ST_IDLE;
                else               state_next_s = ST_DONE;
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // One partial-product step: conditional add into the upper half, then shift right.
    always_comb begin
        hi_s = acc_r[2*WIDTH:WIDTH];
`ifdef SIGNED_MULT_EN
        // The multiplier's sign bit carries negative weight, so the last step subtracts.
        if (acc_r[0]) begin
            if (last_s) hi_s = acc_r[2*WIDTH:WIDTH] - {mcand_r[WIDTH-1], mcand_r};
            else        hi_s = acc_r[2*WIDTH:WIDTH] + {mcand_r[WIDTH-1], mcand_r};
        end else begin
            hi_s = acc_r[2*WIDTH:WIDTH];
        end
        acc_next_s = {hi_s[WIDTH], hi_s, acc_r[WIDTH-1:1]};
`else
        if (acc_r[0]) hi_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + {1'b0, mcand_r};
        else          hi_s = acc_r[2*WIDTH:WIDTH];
        acc_next_s = {1'b0, hi_s, acc_r[WIDTH-1:1]};
`endif
    end

    // State register with handshake flags registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            in_ready_r  <= (state_next_s == ST_IDLE);
            out_valid_r <= (state_next_s == ST_DONE);
            busy_r      <= (state_next_s == ST_RUN);
        end
    end

    // Operand capture, shift-add datapath and product latch on entry to DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_r   <= {WIDTH{1'b0}};
            acc_r     <= {(2*WIDTH+1){1'b0}};
            cnt_r     <= {CW{1'b0}};
            product_r <= {(2*WIDTH){1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        mcand_r <= bus.a;
                        acc_r   <= {{(WIDTH+1){1'b0}}, bus.b};
                        cnt_r   <= {CW{1'b0}};
                    end
                end
                ST_RUN: begin
                    acc_r <= acc_next_s;
                    cnt_r <= cnt_r + CW'(1);
                    if (last_s) product_r <= acc_next_s[2*WIDTH-1:0];
                end
                ST_DONE: begin
                    acc_r <= acc_r;
                end
                default: begin
                    acc_r <= {(2*WIDTH+1){1'b0}};
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.busy      = busy_r;
    assign bus.product   = product_r;
endmodule
